// File: rtl/fb_pipectrl_pkg.sv
// Shared types and constants for the Firebird pipeline sequencing controller.
package fb_pipectrl_pkg;

  localparam int FB_32BITS       = 32;
  localparam int FB_DMEM_TIMEOUT = 255;
  localparam int FB_REG_W        = 5;
  localparam int FB_WAIT_W       = 8;

  typedef enum logic {
    FB_PC_RUN   = 1'b0,
    FB_PC_MWAIT = 1'b1
  } pc_state_e;

  // Bundle of per-register enables and flushes driven each cycle.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RESET    = 7'b00000_11;
  localparam pipe_ctrl_t CTRL_FREEZE   = 7'b00000_00;
  localparam pipe_ctrl_t CTRL_BRANCH   = 7'b11111_11;
  localparam pipe_ctrl_t CTRL_LOAD_USE = 7'b00111_01;
  localparam pipe_ctrl_t CTRL_ADVANCE  = 7'b11111_00;

endpackage

// File: rtl/fb_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the rd of a load in EX.
module fb_hazard_detect
  import fb_pipectrl_pkg::*;
(
  input  logic [FB_REG_W-1:0] id_rs1_i,
  input  logic [FB_REG_W-1:0] id_rs2_i,
  input  logic                id_use_rs1_i,
  input  logic                id_use_rs2_i,
  input  logic                ex_mem_to_reg_i,
  input  logic [FB_REG_W-1:0] ex_rd_i,
  output logic                load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use_o = ex_mem_to_reg_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/fb_pipectrl.sv
// Pipeline sequencing controller: memory-wait FSM with timeout, branch/load-use
// priority mux for register enables and flushes, and a stall-cycle counter.
module fb_pipectrl
  import fb_pipectrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = FB_DMEM_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FB_REG_W-1:0]  id_rs1,
  input  logic [FB_REG_W-1:0]  id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_mem_to_reg,
  input  logic [FB_REG_W-1:0]  ex_register_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_mem_read,
  input  logic                 mem_mem_write,
  input  logic                 dmem_ready,
  output logic                 dmem_req,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 idex_we,
  output logic                 exmem_we,
  output logic                 memwb_we,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 dmem_timeout,
  output logic [FB_32BITS-1:0] stall_cnt
);

  localparam logic [FB_WAIT_W-1:0] WAIT_LAST = FB_WAIT_W'(TIMEOUT - 1);

  pc_state_e            state_q, state_d;
  logic [FB_WAIT_W-1:0] wait_q, wait_d;
  logic                 timeout_q, timeout_d;
  logic [FB_32BITS-1:0] stall_cnt_q, stall_cnt_d;

  logic       mem_acc;
  logic       mem_wait;
  logic       freeze;
  logic       load_use;
  pipe_ctrl_t ctrl;

  fb_hazard_detect u_hazard (
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_use_rs1_i    (id_use_rs1),
    .id_use_rs2_i    (id_use_rs2),
    .ex_mem_to_reg_i (ex_mem_to_reg),
    .ex_rd_i         (ex_register_rd),
    .load_use_o      (load_use)
  );

  assign mem_acc  = mem_mem_read || mem_mem_write;
  assign mem_wait = mem_acc && !dmem_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    freeze    = mem_wait;
    if (state_q == FB_PC_RUN) begin
      if (mem_wait) begin
        state_d = FB_PC_MWAIT;
        wait_d  = '0;
      end
    end else if (!mem_wait) begin
      state_d = FB_PC_RUN;
    end else if (wait_q == WAIT_LAST) begin
      // Abandon the access: the cycle completes with undefined read data.
      state_d   = FB_PC_RUN;
      timeout_d = 1'b1;
      freeze    = 1'b0;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  // A branch seen while frozen simply re-presents itself on the release cycle.
  always_comb begin
    if (rst)                  ctrl = CTRL_RESET;
    else if (freeze)          ctrl = CTRL_FREEZE;
    else if (ex_branch_taken) ctrl = CTRL_BRANCH;
    else if (load_use)        ctrl = CTRL_LOAD_USE;
    else                      ctrl = CTRL_ADVANCE;
  end

  assign stall_cnt_d = ctrl.pc_we ? stall_cnt_q : stall_cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FB_PC_RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_req     = mem_acc && !rst;
  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign idex_we      = ctrl.idex_we;
  assign exmem_we     = ctrl.exmem_we;
  assign memwb_we     = ctrl.memwb_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign dmem_timeout = timeout_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fb_pipectrl.sv
// Directed self-checking bench for fb_pipectrl (TIMEOUT=4).
module tb_fb_pipectrl;
  import fb_pipectrl_pkg::*;

  // Packed view: {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, dmem_req}
  localparam logic [7:0] O_RST     = 8'b00000_11_0;
  localparam logic [7:0] O_NORMAL  = 8'b11111_00_0;
  localparam logic [7:0] O_LDUSE   = 8'b00111_01_0;
  localparam logic [7:0] O_BRANCH  = 8'b11111_11_0;
  localparam logic [7:0] O_STALL   = 8'b00000_00_1;
  localparam logic [7:0] O_ADV_REQ = 8'b11111_00_1;
  localparam logic [7:0] O_BR_REQ  = 8'b11111_11_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_register_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_to_reg, ex_branch_taken;
  logic       mem_mem_read, mem_mem_write, dmem_ready;
  logic       dmem_req, pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       ifid_flush, idex_flush, dmem_timeout;
  logic [31:0] stall_cnt;

  int passed = 0;
  int total  = 0;
  int exp_stall = 0;

  fb_pipectrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_register_rd(ex_register_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  wire [7:0] outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, dmem_req};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_to_reg = 0; ex_register_rd = 0; ex_branch_taken = 0;
    mem_mem_read = 0; mem_mem_write = 0; dmem_ready = 0;
  endtask

  task automatic set_load_use();
    ex_mem_to_reg = 1; ex_register_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    check("rst_outs", 32'(outs), 32'(O_RST));
    check("rst_cnt", stall_cnt, 0);
    check("rst_to", 32'(dmem_timeout), 0);
    mem_mem_read = 1;
    #1 check("rst_req_gated", 32'(outs), 32'(O_RST));
    idle();
    @(negedge clk) rst = 1'b0;
    #1 check("normal", 32'(outs), 32'(O_NORMAL));

    // Load-use: one bubble cycle
    set_load_use();
    #1 check("lduse", 32'(outs), 32'(O_LDUSE));
    @(negedge clk); exp_stall++;
    check("lduse_cnt", stall_cnt, exp_stall);
    ex_mem_to_reg = 0;
    #1 check("lduse_after", 32'(outs), 32'(O_NORMAL));
    @(negedge clk);
    check("lduse_cnt2", stall_cnt, exp_stall);

    // Hazard corner cases (combinational only)
    idle(); ex_mem_to_reg = 1; ex_register_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1 check("rd0_nohaz", 32'(outs), 32'(O_NORMAL));
    ex_register_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
    #1 check("nouse_nohaz", 32'(outs), 32'(O_NORMAL));
    id_use_rs1 = 1;
    #1 check("rs1_haz", 32'(outs), 32'(O_LDUSE));
    idle();

    // Branch wins over load-use
    set_load_use(); ex_branch_taken = 1;
    #1 check("br_lduse", 32'(outs), 32'(O_BRANCH));
    @(negedge clk);
    check("br_cnt", stall_cnt, exp_stall);
    idle();

    // Memory wait: ready low 3 cycles then high
    mem_mem_read = 1;
    #1 check("mw_st0", 32'(outs), 32'(O_STALL));
    check("mw_run0", 32'(dut.state_q), 32'(FB_PC_RUN));
    @(negedge clk); exp_stall++;
    check("mw_mwait", 32'(dut.state_q), 32'(FB_PC_MWAIT));
    for (int i = 0; i < 2; i++) begin
      #1 check("mw_st", 32'(outs), 32'(O_STALL));
      @(negedge clk); exp_stall++;
    end
    check("mw_cnt", stall_cnt, exp_stall);
    dmem_ready = 1;
    #1 check("mw_release", 32'(outs), 32'(O_ADV_REQ));
    @(negedge clk);
    check("mw_run", 32'(dut.state_q), 32'(FB_PC_RUN));
    check("mw_cnt2", stall_cnt, exp_stall);
    idle();

    // Zero-wait write
    mem_mem_write = 1; dmem_ready = 1;
    #1 check("zw", 32'(outs), 32'(O_ADV_REQ));
    @(negedge clk);
    check("zw_run", 32'(dut.state_q), 32'(FB_PC_RUN));
    check("zw_cnt", stall_cnt, exp_stall);
    idle();

    // Branch held during 2-cycle wait
    mem_mem_read = 1; ex_branch_taken = 1;
    for (int i = 0; i < 2; i++) begin
      #1 check("brw_st", 32'(outs), 32'(O_STALL));
      @(negedge clk); exp_stall++;
    end
    dmem_ready = 1;
    #1 check("brw_release", 32'(outs), 32'(O_BR_REQ));
    @(negedge clk);
    check("brw_cnt", stall_cnt, exp_stall);
    idle();

    // Timeout: ready stuck low, TIMEOUT=4
    mem_mem_read = 1;
    #1 check("to_st0", 32'(outs), 32'(O_STALL));
    @(negedge clk); exp_stall++;
    for (int i = 0; i < 3; i++) begin
      #1 check("to_st", 32'(outs), 32'(O_STALL));
      check("to_flag_lo", 32'(dmem_timeout), 0);
      @(negedge clk); exp_stall++;
    end
    #1 check("to_adv", 32'(outs), 32'(O_ADV_REQ));
    check("to_flag_pre", 32'(dmem_timeout), 0);
    @(negedge clk);
    check("to_flag", 32'(dmem_timeout), 1);
    check("to_run", 32'(dut.state_q), 32'(FB_PC_RUN));
    check("to_cnt", stall_cnt, exp_stall);
    idle();
    @(negedge clk);
    check("to_sticky", 32'(dmem_timeout), 1);
    check("to_normal", 32'(outs), 32'(O_NORMAL));

    // Async reset mid-MWAIT
    mem_mem_read = 1;
    @(negedge clk);
    check("ar_mwait", 32'(dut.state_q), 32'(FB_PC_MWAIT));
    #1 rst = 1'b1;
    #1;
    check("ar_state", 32'(dut.state_q), 32'(FB_PC_RUN));
    check("ar_cnt", stall_cnt, 0);
    check("ar_to", 32'(dmem_timeout), 0);
    check("ar_outs", 32'(outs), 32'(O_RST));
    idle();
    @(negedge clk) rst = 1'b0;
    #1 check("ar_normal", 32'(outs), 32'(O_NORMAL));
    @(negedge clk);
    check("ar_cnt2", stall_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
